// File: rtl/pipe_memwb_stage.sv
// rtl/pipe_memwb_stage.sv - MEM/WB pipeline register chain with writeback select and forwarding
module pipe_memwb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [REG_W-1:0]  src_a,
    input  logic [REG_W-1:0]  src_b,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b
);

    localparam int LAST = DEPTH - 1;

    logic              st_valid [DEPTH];
    logic              st_rw    [DEPTH];
    logic              st_m2r   [DEPTH];
    logic [DATA_W-1:0] st_rd    [DEPTH];
    logic [DATA_W-1:0] st_alu   [DEPTH];
    logic [REG_W-1:0]  st_dest  [DEPTH];
    logic [DATA_W-1:0] st_sel   [DEPTH];
    logic              st_wr    [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_valid[k] <= 1'b0;
                st_rw[k]    <= 1'b0;
                st_m2r[k]   <= 1'b0;
                st_rd[k]    <= '0;
                st_alu[k]   <= '0;
                st_dest[k]  <= '0;
            end
        end else begin
            // A flush always lands a bubble in stage 0, even while the rest of the chain is stalled
            if (flush) begin
                st_valid[0] <= 1'b0;
                st_rw[0]    <= 1'b0;
                st_m2r[0]   <= in_mem_to_reg;
                st_rd[0]    <= in_read_data;
                st_alu[0]   <= in_alu_result;
                st_dest[0]  <= in_dest;
            end else if (!stall) begin
                st_valid[0] <= in_valid;
                st_rw[0]    <= in_valid & in_reg_write;
                st_m2r[0]   <= in_mem_to_reg;
                st_rd[0]    <= in_read_data;
                st_alu[0]   <= in_alu_result;
                st_dest[0]  <= in_dest;
            end
            if (!stall) begin
                for (int k = 1; k < DEPTH; k++) begin
                    st_valid[k] <= st_valid[k-1];
                    st_rw[k]    <= st_rw[k-1];
                    st_m2r[k]   <= st_m2r[k-1];
                    st_rd[k]    <= st_rd[k-1];
                    st_alu[k]   <= st_alu[k-1];
                    st_dest[k]  <= st_dest[k-1];
                end
            end
        end
    end

    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            st_sel[k] = st_m2r[k] ? st_rd[k] : st_alu[k];
            st_wr[k]  = st_valid[k] & st_rw[k] & (st_dest[k] != '0);
        end
        // Scan oldest to youngest so the youngest qualifying writer wins
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (st_wr[k] && (st_dest[k] == src_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = st_sel[k];
            end
            if (st_wr[k] && (st_dest[k] == src_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = st_sel[k];
            end
        end
    end

    assign wb_we     = st_wr[LAST];
    assign wb_dest   = st_dest[LAST];
    assign wb_data   = st_sel[LAST];
    assign out_valid = st_valid[LAST];

endmodule

// File: tb/tb_pipe_memwb_stage.sv
// tb/tb_pipe_memwb_stage.sv - scoreboard bench for pipe_memwb_stage at DEPTH 1..4
module tb_pipe_memwb_stage;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid, in_reg_write, in_mem_to_reg;
    logic [31:0] in_read_data, in_alu_result;
    logic [4:0]  in_dest, src_a, src_b;

    logic        wb_we_o     [4];
    logic [4:0]  wb_dest_o   [4];
    logic [31:0] wb_data_o   [4];
    logic        out_valid_o [4];
    logic        fwd_hit_a_o [4];
    logic [31:0] fwd_data_a_o[4];
    logic        fwd_hit_b_o [4];
    logic [31:0] fwd_data_b_o[4];

    exp_t sbq [4][$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pipe_memwb_stage #(.DATA_W(32), .REG_W(5), .DEPTH(g + 1)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .stall        (stall),
            .flush        (flush),
            .in_valid     (in_valid),
            .in_reg_write (in_reg_write),
            .in_mem_to_reg(in_mem_to_reg),
            .in_read_data (in_read_data),
            .in_alu_result(in_alu_result),
            .in_dest      (in_dest),
            .src_a        (src_a),
            .src_b        (src_b),
            .wb_we        (wb_we_o[g]),
            .wb_dest      (wb_dest_o[g]),
            .wb_data      (wb_data_o[g]),
            .out_valid    (out_valid_o[g]),
            .fwd_hit_a    (fwd_hit_a_o[g]),
            .fwd_data_a   (fwd_data_a_o[g]),
            .fwd_hit_b    (fwd_hit_b_o[g]),
            .fwd_data_b   (fwd_data_b_o[g])
        );
    end

    task automatic clear_sb();
        for (int d = 0; d < 4; d++) sbq[d].delete();
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r,
                          input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] dst);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
        in_read_data = rd; in_alu_result = alu; in_dest = dst;
    endtask

    // Drive one entry with stall low, record its expected writeback, and retire any entry due out
    task automatic push_entry(input logic v, input logic rw, input logic m2r, input logic fl,
                              input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] dst);
        exp_t e;
        @(negedge clk);
        set_in(v, rw, m2r, rd, alu, dst);
        stall = 1'b0;
        flush = fl;
        e.valid = v & ~fl;
        e.we    = e.valid & rw & (dst != 5'd0);
        e.dest  = dst;
        e.data  = m2r ? rd : alu;
        for (int d = 0; d < 4; d++) sbq[d].push_back(e);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (sbq[d].size() == d + 1) begin
                e = sbq[d].pop_front();
                n_vec++;
                if ({wb_we_o[d], wb_dest_o[d], wb_data_o[d], out_valid_o[d]} !==
                    {e.we, e.dest, e.data, e.valid}) begin
                    n_err++;
                    $display("FAIL sb_depth%0d: got we=%b dest=%0d data=%h valid=%b expected we=%b dest=%0d data=%h valid=%b",
                             d + 1, wb_we_o[d], wb_dest_o[d], wb_data_o[d], out_valid_o[d],
                             e.we, e.dest, e.data, e.valid);
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic drain();
        repeat (4) push_entry(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        clear_sb();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h5555_AAAA, 5'd8);
        src_a = 5'd8; src_b = 5'd8;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if ({wb_we_o[d], wb_dest_o[d], wb_data_o[d], out_valid_o[d], fwd_hit_a_o[d],
                     fwd_data_a_o[d], fwd_hit_b_o[d], fwd_data_b_o[d]} !== 104'd0) begin
                    n_err++;
                    $display("FAIL reset_depth%0d: got we=%b dest=%0d data=%h valid=%b ha=%b hb=%b expected all zero",
                             d + 1, wb_we_o[d], wb_dest_o[d], wb_data_o[d], out_valid_o[d],
                             fwd_hit_a_o[d], fwd_hit_b_o[d]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
    endtask

    task automatic test_latency();
        push_entry(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 5'd8);
    endtask

    task automatic test_mem_select();
        push_entry(1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0BAD, 5'd0);
        push_entry(1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0BAD, 5'd3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            push_entry(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 7) == 0), $urandom, $urandom,
                       5'($urandom_range(0, 7)));
        drain();
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00A5, 5'd5);
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00C6, 5'd6);
        @(negedge clk);
        stall = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_B0B0, 5'd10);
        src_a = 5'd5; src_b = 5'd6;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({wb_we_o[1], wb_dest_o[1], wb_data_o[1], out_valid_o[1]} !== {1'b1, 5'd5, 32'hA5, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold_d2: got we=%b dest=%0d data=%h expected we=1 dest=5 data=a5",
                         wb_we_o[1], wb_dest_o[1], wb_data_o[1]);
            end
            n_vec++;
            if ({fwd_hit_a_o[1], fwd_data_a_o[1], fwd_hit_b_o[1], fwd_data_b_o[1]} !==
                {1'b1, 32'hA5, 1'b1, 32'hC6}) begin
                n_err++;
                $display("FAIL stall_fwd_d2: got ha=%b da=%h hb=%b db=%h expected ha=1 da=a5 hb=1 db=c6",
                         fwd_hit_a_o[1], fwd_data_a_o[1], fwd_hit_b_o[1], fwd_data_b_o[1]);
            end
            n_vec++;
            if (wb_dest_o[0] !== 5'd6) begin
                n_err++;
                $display("FAIL stall_hold_d1: got dest=%0d expected 6", wb_dest_o[0]);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({wb_dest_o[1], out_valid_o[1], fwd_hit_b_o[1], fwd_data_b_o[1]} !== {5'd5, 1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL flush_stall_d2: got dest=%0d valid=%b hb=%b db=%h expected dest=5 valid=1 hb=0 db=0",
                     wb_dest_o[1], out_valid_o[1], fwd_hit_b_o[1], fwd_data_b_o[1]);
        end
        n_vec++;
        if ({wb_we_o[0], wb_dest_o[0], wb_data_o[0], out_valid_o[0]} !== {1'b0, 5'd10, 32'hB0B0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_bubble_d1: got we=%b dest=%0d data=%h valid=%b expected we=0 dest=10 data=b0b0 valid=0",
                     wb_we_o[0], wb_dest_o[0], wb_data_o[0], out_valid_o[0]);
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00D9, 5'd9);
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid_o[1], wb_we_o[1]} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_slot_d2: got valid=%b we=%b expected 0 0", out_valid_o[1], wb_we_o[1]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({wb_we_o[1], wb_dest_o[1], wb_data_o[1], out_valid_o[1]} !== {1'b1, 5'd9, 32'hD9, 1'b1}) begin
            n_err++;
            $display("FAIL after_flush_d2: got we=%b dest=%0d data=%h expected we=1 dest=9 data=d9",
                     wb_we_o[1], wb_dest_o[1], wb_data_o[1]);
        end
    endtask

    task automatic test_forwarding();
        drain();
        push_entry(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h11, 5'd7);
        push_entry(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h33, 5'd12);
        push_entry(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h22, 5'd7);
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd9);
        src_a = 5'd7; src_b = 5'd9;
        #1;
        for (int d = 2; d < 4; d++) begin
            n_vec++;
            if ({fwd_hit_a_o[d], fwd_data_a_o[d], fwd_hit_b_o[d], fwd_data_b_o[d]} !==
                {1'b1, 32'h22, 1'b0, 32'h0}) begin
                n_err++;
                $display("FAIL fwd_prio_depth%0d: got ha=%b da=%h hb=%b db=%h expected ha=1 da=22 hb=0 db=0",
                         d + 1, fwd_hit_a_o[d], fwd_data_a_o[d], fwd_hit_b_o[d], fwd_data_b_o[d]);
            end
        end
        src_b = 5'd12;
        #1;
        n_vec++;
        if ({fwd_hit_b_o[2], fwd_data_b_o[2]} !== {1'b1, 32'h44}) begin
            n_err++;
            $display("FAIL fwd_memsel_d3: got hb=%b db=%h expected hb=1 db=44", fwd_hit_b_o[2], fwd_data_b_o[2]);
        end
        in_valid = 1'b0;
        clear_sb();
    endtask

    task automatic test_invalid();
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 5'd4);
        src_a = 5'd4; src_b = 5'd0;
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h66, 5'd4);
        #1;
        n_vec++;
        if ({fwd_hit_a_o[0], wb_we_o[0], out_valid_o[0], wb_dest_o[0]} !== {1'b0, 1'b0, 1'b0, 5'd4}) begin
            n_err++;
            $display("FAIL invalid_entry: got ha=%b we=%b valid=%b dest=%0d expected ha=0 we=0 valid=0 dest=4",
                     fwd_hit_a_o[0], wb_we_o[0], out_valid_o[0], wb_dest_o[0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if ({fwd_hit_a_o[0], wb_we_o[0], out_valid_o[0], fwd_hit_a_o[1], wb_we_o[1]} !== 5'b00100) begin
            n_err++;
            $display("FAIL nowrite_entry: got ha=%b we=%b valid=%b ha_d2=%b we_d2=%b expected 0 0 1 0 0",
                     fwd_hit_a_o[0], wb_we_o[0], out_valid_o[0], fwd_hit_a_o[1], wb_we_o[1]);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 5'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        src_a = 5'd1; src_b = 5'd4;
        #1;
        n_vec++;
        if ({out_valid_o[3], fwd_hit_a_o[3], fwd_data_a_o[3], fwd_hit_b_o[3], fwd_data_b_o[3]} !==
            {1'b1, 1'b1, 32'h101, 1'b1, 32'h104}) begin
            n_err++;
            $display("FAIL full_d4: got valid=%b ha=%b da=%h hb=%b db=%h expected 1 1 101 1 104",
                     out_valid_o[3], fwd_hit_a_o[3], fwd_data_a_o[3], fwd_hit_b_o[3], fwd_data_b_o[3]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid_o[3], fwd_hit_a_o[3], fwd_hit_b_o[3], wb_we_o[3]} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_d4: got valid=%b ha=%b hb=%b we=%b expected all 0",
                     out_valid_o[3], fwd_hit_a_o[3], fwd_hit_b_o[3], wb_we_o[3]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        src_a = 5'd0; src_b = 5'd0;
        test_reset();
        test_latency();
        test_mem_select();
        test_back_to_back();
        test_stall_flush();
        test_forwarding();
        test_invalid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
